// File: rtl/eight_bit_cpu_pkg.sv
// Shared definitions for the 8-bit processor: opcodes, fetch-stage states and
// the instruction word width.
package eight_bit_cpu_pkg;

  localparam int INSTR_W = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_LDA  = 4'h6;
  localparam logic [3:0] OP_STA  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_OUTA = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_VALID,
    FETCH_HALT
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                   input logic [3:0] halt_op);
    return instr[INSTR_W-1 -: 4] == halt_op;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage: load has priority over increment and
// the increment wraps naturally at 2^ADDR_W.
module fetch_pc #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= load_addr;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/eight_bit_fetch_unit.sv
// Instruction fetch stage: reads the synchronous program memory at pc and hands
// each word to the control unit over valid/ready, handling jumps and HALT.
//
// state | meaning
// IDLE  | after reset, waiting for run
// REQ   | mem_rd asserted at mem_addr = pc
// WAIT  | read data returns, captured into instr
// VALID | instr_valid, waiting for instr_ready
// HALT  | HALT accepted, waiting for run
module eight_bit_fetch_unit
  import eight_bit_cpu_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter logic [3:0] HALT_OP = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  w_pc;
  logic               w_handshake;

  assign w_handshake = (r_state == FETCH_VALID) && instr_ready;

  fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_handshake && branch_en),
    .inc       (w_handshake && !branch_en),
    .load_addr (branch_addr),
    .pc        (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_IDLE:  if (run) w_state_next = FETCH_REQ;
      FETCH_REQ:   w_state_next = FETCH_WAIT;
      FETCH_WAIT:  w_state_next = FETCH_VALID;
      FETCH_VALID: begin
        // A branch on a HALT word still updates pc but the halt is taken.
        if (w_handshake) begin
          w_state_next = is_halt(r_instr, HALT_OP) ? FETCH_HALT : FETCH_REQ;
        end
      end
      FETCH_HALT:  if (run) w_state_next = FETCH_REQ;
      default:     w_state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
    end else if (r_state == FETCH_WAIT) begin
      r_instr <= mem_rdata;
    end
  end

  assign mem_rd      = (r_state == FETCH_REQ);
  assign mem_addr    = w_pc;
  assign pc          = w_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == FETCH_VALID);
  assign halted      = (r_state == FETCH_HALT);

endmodule

// File: doc/eight_bit_fetch_unit.md
# eight_bit_fetch_unit

Instruction fetch stage for the 8-bit processor, directly upstream of `eight_bit_control_unit`. Holds the program counter and reads 8-bit instruction words from a synchronous program memory with 1-cycle read latency. Presents each word to the control unit over a valid/ready handshake. Also handles jumps and the HALT opcode.

## Interface
Parameters:
- `ADDR_W`, default 4: program-address width; program depth is 2^ADDR_W words.
- `HALT_OP`, default 4'hF: opcode in `instr[7:4]` that halts fetch.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `run`  in  1  Start/resume pulse. Honoured only in IDLE or HALT.
- `mem_rd`  out  1  Program-memory read strobe.
- `mem_addr`  out  ADDR_W  Program-memory address. Always equals `pc`.
- `mem_rdata`  in  8  Read data, valid the cycle after `mem_rd`.
- `instr`  out  8  Instruction to the control unit.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  Control unit accepts `instr`.
- `branch_en`  in  1  Redirect the PC. Sampled only on a handshake.
- `branch_addr`  in  ADDR_W  Redirect target.
- `pc`  out  ADDR_W  Current program counter (debug).
- `halted`  out  1  High while in the HALT state.

## Operation
States:
- IDLE (reset state)
  - `run` → REQ.
- REQ
  - `mem_rd`=1, `mem_addr`=`pc`.
  - Unconditional → WAIT.
- WAIT
  - `mem_rdata` is captured into `instr` on the edge.
  - → VALID.
- VALID
  - `instr_valid`=1; `instr` held stable.
  - Without `instr_ready`: stay in VALID; `pc` and `instr` unchanged.
  - With `instr_ready` (handshake):
    - Next `pc` = `branch_addr` if `branch_en`=1, else `pc`+1, wrapping modulo 2^ADDR_W.
    - Next state = HALT if `instr[7:4]`==`HALT_OP`, else REQ.
    - `branch_en` takes priority for the PC update on a HALT instruction too, but does not prevent the transition to HALT.
- HALT
  - `halted`=1, `mem_rd`=0.
  - `run` → REQ, fetching from the already-updated `pc`.

Other rules:
- `branch_en` outside a VALID handshake is ignored.
- `run` in REQ, WAIT or VALID is ignored.
- `mem_rd` is 1 only in REQ. `instr_valid` is 1 only in VALID.

Reset (asynchronous, any state, including mid-fetch):
- State → IDLE.
- `pc`=0, `instr`=8'h00.
- `instr_valid`=0, `mem_rd`=0, `halted`=0.
- `mem_addr`=0.
- An in-flight `mem_rdata` is discarded.

## Timing
- All outputs are registered or decoded from state/`pc` only; there are no combinational paths from inputs to outputs.
- `run` sampled high at edge 0:
  - REQ during cycle 1.
  - Data returned during cycle 2.
  - `instr_valid` high from cycle 3.
- With `instr_ready` held high, one instruction every 3 cycles (VALID → REQ → WAIT → VALID).
- A branch takes effect on the next REQ: `mem_addr`=`branch_addr` one cycle after the handshake.
- After a halt handshake, `halted` rises the next cycle. A `run` pulse in HALT gives REQ the following cycle.

## Structure
Shared package `eight_bit_cpu_pkg` holds:
- opcode constants (`OP_ADD`=4'h0 … `OP_OUTA`=4'hB, `OP_HALT`=4'hF);
- the fetch-state enum (IDLE, REQ, WAIT, VALID, HALT);
- `INSTR_W`=8.

One natural sub-module, `fetch_pc`:
- ADDR_W-bit register with async active-low clear;
- `load`/`inc` controls, `load` having priority;
- implicit wrap on increment.

The FSM and the instruction register stay in the top module.

## Test plan
- Sequential fetch: memory = 0x01, 0x12, 0x23; `run` at cycle 0; `instr_ready`=1 → `instr`=0x01 valid at cycle 3, 0x12 at cycle 6, 0x23 at cycle 9; `mem_addr` 0, 1, 2 during REQ cycles.
- Backpressure: `instr_ready`=0 for 5 cycles in VALID with `instr`=0x12 → `instr_valid` stays 1, `instr`=0x12, `mem_rd`=0 and `pc`=1 throughout; next handshake → REQ at address 2.
- Branch: handshake on address 2 with `branch_en`=1, `branch_addr`=0xA → next REQ has `mem_addr`=0xA. `branch_en`=1 pulsed while in WAIT → no effect.
- Halt and resume: address 3 = 0xF0 → after its handshake `halted`=1, `mem_rd` stays 0 for 10 cycles; `run` → `halted`=0, REQ at address 4.
- Wrap: `branch_addr`=0xF, the word there is accepted without a branch → next REQ at address 0.
- Reset mid-operation: assert `rst_n`=0 during WAIT → immediately `instr_valid`=0, `mem_rd`=0, `pc`=0, `instr`=0x00; after release, no activity until `run`.
